// File: rtl/tag_pkg.sv
// Shared types and constants for the tag pool arbiter and its free-list FIFO.
package tag_pkg;

  localparam int unsigned tag_w      = 6;
  localparam int unsigned POOL_DEPTH = 2**tag_w;
  localparam int unsigned LANES      = 2;

  typedef logic [tag_w-1:0] tag_t;
  typedef logic [tag_w:0]   pool_cnt_t;

  typedef enum logic {POOL_INIT, POOL_RUN} pool_state_e;

  localparam pool_cnt_t POOL_FULL = pool_cnt_t'(POOL_DEPTH);

  // Push payload into the free list; valid bits are compacted towards slot 0.
  typedef struct packed {
    logic [LANES-1:0]       vld;
    tag_t [LANES-1:0]       tag;
  } tag_pair_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return 2'(v[0]) + 2'(v[1]);
  endfunction

endpackage

// File: rtl/tag_pool_arbiter_if.sv
// Issue/retire bus between the tag pool arbiter and the tag hub lanes.
interface tag_pool_arbiter_if;
  import tag_pkg::*;

  logic            ready_o;
  logic [1:0]      issue_req_i;
  logic [1:0]      issue_gnt_o;
  tag_t [1:0]      issue_tag_o;
  logic [1:0]      retire_vld_i;
  tag_t [1:0]      retire_tag_i;
  pool_cnt_t       free_cnt_o;
  logic            err_o;

  modport master (
    input  ready_o, issue_gnt_o, issue_tag_o, free_cnt_o, err_o,
    output issue_req_i, retire_vld_i, retire_tag_i
  );

  modport slave (
    output ready_o, issue_gnt_o, issue_tag_o, free_cnt_o, err_o,
    input  issue_req_i, retire_vld_i, retire_tag_i
  );

endinterface

// File: rtl/tag_free_fifo.sv
// Dual-push / dual-pop circular free list with head, tail and occupancy count.
module tag_free_fifo
  import tag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init_wr,
  input  tag_t       init_idx,
  input  logic       init_done,
  input  logic [1:0] pop_n,
  input  tag_pair_t  push,
  output tag_t [1:0] rd_tag_c,
  output pool_cnt_t  count
);

  tag_t       mem [POOL_DEPTH];
  tag_t       head;
  tag_t       tail;
  tag_t       head_p1;
  tag_t       tail_p1;
  logic [1:0] push_n;

  assign head_p1 = head + tag_t'(1);
  assign tail_p1 = tail + tag_t'(1);
  assign push_n  = popcnt2(push.vld);

  assign rd_tag_c[0] = mem[head];
  assign rd_tag_c[1] = mem[head_p1];

  // Storage carries no reset; the INIT fill defines every entry before use.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[init_idx] <= init_idx;
    end else begin
      if (push.vld[0]) mem[tail]    <= push.tag[0];
      if (push.vld[1]) mem[tail_p1] <= push.tag[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (init_done) begin
      head  <= '0;
      tail  <= '0;
      count <= POOL_FULL;
    end else begin
      head  <= head + tag_t'(pop_n);
      tail  <= tail + tag_t'(push_n);
      count <= count + pool_cnt_t'(push_n) - pool_cnt_t'(pop_n);
    end
  end

endmodule

// File: rtl/tag_pool_arbiter.sv
// Tag pool arbiter: fills the free list after reset, then grants up to two tags
// and accepts up to two retires per cycle. Optional double-free bitmap: TAG_POOL_DFREE_CHECK_EN.
module tag_pool_arbiter
  import tag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  tag_pool_arbiter_if.slave  bus
);

  pool_state_e state;
  pool_state_e state_next;
  tag_t        fill;
  tag_t        fill_next;
  logic        init_wr_c;
  logic        init_last_c;

  logic        run_c;
  logic        rr_ptr;
  logic        rr_flip_c;
  logic        err;
  logic [1:0]  gnt_c;
  tag_t [1:0]  gnt_tag_c;
  tag_t [1:0]  rd_tag_c;
  pool_cnt_t   free_cnt;
  pool_cnt_t   room_c;
  logic [1:0]  ret_vld_c;
  logic [1:0]  chk_vld_c;
  logic [1:0]  acc_vld_c;
  logic        init_err_c;
  logic        dup_err_c;
  logic        ovf_err_c;
  tag_pair_t   push_c;

  assign run_c = (state == POOL_RUN);

  // State register and fill counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= POOL_INIT;
      fill  <= '0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
    end
  end

  always_comb begin
    state_next  = state;
    fill_next   = fill;
    init_wr_c   = 1'b0;
    init_last_c = 1'b0;
    case (state)
      POOL_INIT: begin
        init_wr_c = 1'b1;
        fill_next = fill + tag_t'(1);
        if (fill == tag_t'(POOL_DEPTH - 1)) begin
          init_last_c = 1'b1;
          state_next  = POOL_RUN;
        end
      end
      POOL_RUN: state_next = POOL_RUN;
      default:  state_next = POOL_INIT;
    endcase
  end

  // Grants from the registered count only; same-cycle retires are not bypassed.
  always_comb begin
    gnt_c     = 2'b00;
    rr_flip_c = 1'b0;
    if (run_c) begin
      if (free_cnt >= pool_cnt_t'(2)) begin
        gnt_c = bus.issue_req_i;
      end else if (free_cnt == pool_cnt_t'(1)) begin
        if (bus.issue_req_i == 2'b11) begin
          gnt_c     = rr_ptr ? 2'b10 : 2'b01;
          rr_flip_c = 1'b1;
        end else begin
          gnt_c = bus.issue_req_i;
        end
      end
    end
  end

  // A lone lane-1 grant takes the head entry, a dual grant takes head+1.
  assign gnt_tag_c[0] = rd_tag_c[0];
  assign gnt_tag_c[1] = gnt_c[0] ? rd_tag_c[1] : rd_tag_c[0];

  assign ret_vld_c  = run_c ? bus.retire_vld_i : 2'b00;
  assign init_err_c = !run_c && (bus.retire_vld_i != 2'b00);
  assign room_c     = POOL_FULL - free_cnt;

`ifdef TAG_POOL_DFREE_CHECK_EN
  logic [POOL_DEPTH-1:0] in_use;
  logic [POOL_DEPTH-1:0] in_use_next;

  // Only tags currently outstanding may come back; lane 0 wins a same-tag collision.
  always_comb begin
    chk_vld_c[0] = ret_vld_c[0] && in_use[bus.retire_tag_i[0]];
    chk_vld_c[1] = ret_vld_c[1] && in_use[bus.retire_tag_i[1]] &&
                   !(chk_vld_c[0] && (bus.retire_tag_i[1] == bus.retire_tag_i[0]));
  end

  assign dup_err_c = (ret_vld_c & ~chk_vld_c) != 2'b00;

  always_comb begin
    in_use_next = in_use;
    for (int i = 0; i < int'(LANES); i++) begin
      if (acc_vld_c[i]) in_use_next[bus.retire_tag_i[i]] = 1'b0;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      if (gnt_c[i]) in_use_next[gnt_tag_c[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_use <= '0;
    else      in_use <= in_use_next;
  end
`else
  assign chk_vld_c = ret_vld_c;
  assign dup_err_c = 1'b0;
`endif

  // Retires beyond the remaining room are dropped, lane 1 first.
  always_comb begin
    acc_vld_c = 2'b00;
    if (chk_vld_c == 2'b11) begin
      if (room_c >= pool_cnt_t'(2))      acc_vld_c = 2'b11;
      else if (room_c == pool_cnt_t'(1)) acc_vld_c = 2'b01;
    end else if (room_c != pool_cnt_t'(0)) begin
      acc_vld_c = chk_vld_c;
    end
  end

  assign ovf_err_c = (acc_vld_c != chk_vld_c);

  always_comb begin
    push_c.vld    = (acc_vld_c == 2'b11) ? 2'b11 :
                    (acc_vld_c != 2'b00) ? 2'b01 : 2'b00;
    push_c.tag[0] = acc_vld_c[0] ? bus.retire_tag_i[0] : bus.retire_tag_i[1];
    push_c.tag[1] = bus.retire_tag_i[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (rr_flip_c) rr_ptr <= ~rr_ptr;
      if (init_err_c || dup_err_c || ovf_err_c) err <= 1'b1;
    end
  end

  tag_free_fifo u_free_fifo (
    .clk       (clk),
    .rst       (rst),
    .init_wr   (init_wr_c),
    .init_idx  (fill),
    .init_done (init_last_c),
    .pop_n     (popcnt2(gnt_c)),
    .push      (push_c),
    .rd_tag_c  (rd_tag_c),
    .count     (free_cnt)
  );

  assign bus.ready_o     = run_c;
  assign bus.issue_gnt_o = gnt_c;
  assign bus.issue_tag_o = gnt_tag_c;
  assign bus.free_cnt_o  = free_cnt;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_tag_pool_arbiter.sv
// Scoreboard bench for tag_pool_arbiter: directed issue/retire vectors with hand-computed grants.
module tb_tag_pool_arbiter;
  import tag_pkg::*;

  typedef struct packed {
    logic [1:0] gnt;
    tag_t       t0;
    tag_t       t1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tag_pool_arbiter_if bus();

  tag_pool_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t mon_e;
  logic mon_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; a request cycle queues its expected grant for the monitor.
  task automatic step(input logic [1:0] req, input logic [1:0] rv, input tag_t r0, input tag_t r1,
                      input logic [1:0] eg, input tag_t e0, input tag_t e1);
    bus.issue_req_i     = req;
    bus.retire_vld_i    = rv;
    bus.retire_tag_i[0] = r0;
    bus.retire_tag_i[1] = r1;
    if (req != 2'b00) expq.push_back('{gnt: eg, t0: e0, t1: e1});
    @(posedge clk); #1;
    bus.issue_req_i  = 2'b00;
    bus.retire_vld_i = 2'b00;
  endtask

  // Monitor: compares the combinational grant in every request cycle against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.issue_req_i != 2'b00) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL grant_unexpected: req %b gnt %b with empty queue", bus.issue_req_i, bus.issue_gnt_o);
        end else begin
          mon_e  = expq.pop_front();
          mon_ok = (bus.issue_gnt_o === mon_e.gnt) &&
                   (!mon_e.gnt[0] || bus.issue_tag_o[0] === mon_e.t0) &&
                   (!mon_e.gnt[1] || bus.issue_tag_o[1] === mon_e.t1);
          if (!mon_ok) begin
            n_err++;
            $display("FAIL grant: got gnt %b tags %0d/%0d expected gnt %b tags %0d/%0d",
                     bus.issue_gnt_o, bus.issue_tag_o[0], bus.issue_tag_o[1],
                     mon_e.gnt, mon_e.t0, mon_e.t1);
          end
        end
      end else if (bus.issue_gnt_o != 2'b00) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_spurious: got gnt %b expected 0", bus.issue_gnt_o);
      end
    end
  end

  initial begin
    bus.issue_req_i     = 2'b00;
    bus.retire_vld_i    = 2'b00;
    bus.retire_tag_i[0] = '0;
    bus.retire_tag_i[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    bus.issue_req_i = 2'b11;
    #1;
    chk("rst_gnt", 32'(bus.issue_gnt_o), 0);
    bus.issue_req_i = 2'b00;
    chk("rst_ready", 32'(bus.ready_o), 0);
    chk("rst_free", 32'(bus.free_cnt_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);

    // INIT lasts 64 cycles
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("init_ready", 32'(bus.ready_o), 0);
      @(posedge clk); #1;
    end
    chk("run_ready", 32'(bus.ready_o), 1);
    chk("run_free", 32'(bus.free_cnt_o), 64);

    // Drain with dual grants: tags 0..63 in order
    for (int i = 0; i < 32; i++)
      step(2'b11, 2'b00, '0, '0, 2'b11, tag_t'(2*i), tag_t'(2*i + 1));
    chk("drain_free", 32'(bus.free_cnt_o), 0);

    // Empty pool: denied
    step(2'b11, 2'b00, '0, '0, 2'b00, '0, '0);
    step(2'b01, 2'b00, '0, '0, 2'b00, '0, '0);

    // Retire while empty: no bypass, granted next cycle
    step(2'b01, 2'b01, 6'd5, '0, 2'b00, '0, '0);
    chk("bypass_free", 32'(bus.free_cnt_o), 1);
    step(2'b01, 2'b00, '0, '0, 2'b01, 6'd5, 6'd5);
    chk("regrant_free", 32'(bus.free_cnt_o), 0);

    // One free tag, both requesting: round robin alternates
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 2'b01, tag_t'(20 + k), '0, 2'b00, '0, '0);
      step(2'b11, 2'b00, '0, '0, (k % 2 == 0) ? 2'b01 : 2'b10, tag_t'(20 + k), tag_t'(20 + k));
    end
    chk("rr_free", 32'(bus.free_cnt_o), 0);

    // Single requester leaves the round-robin pointer alone
    step(2'b00, 2'b01, 6'd30, '0, 2'b00, '0, '0);
    step(2'b10, 2'b00, '0, '0, 2'b10, 6'd30, 6'd30);
    step(2'b00, 2'b01, 6'd31, '0, 2'b00, '0, '0);
    step(2'b11, 2'b00, '0, '0, 2'b01, 6'd31, 6'd31);

    // Dual retire ordering: lane 0 at tail, lane 1 at tail+1
    step(2'b00, 2'b11, 6'd40, 6'd41, 2'b00, '0, '0);
    chk("dual_ret_free", 32'(bus.free_cnt_o), 2);
    step(2'b11, 2'b00, '0, '0, 2'b11, 6'd40, 6'd41);
    chk("dual_ret_drain", 32'(bus.free_cnt_o), 0);

    // Refill the whole pool
    for (int i = 0; i < 32; i++)
      step(2'b00, 2'b11, tag_t'(2*i), tag_t'(2*i + 1), 2'b00, '0, '0);
    chk("refill_free", 32'(bus.free_cnt_o), 64);
    chk("refill_err", 32'(bus.err_o), 0);

    // Overflow at full
    step(2'b00, 2'b01, 6'd7, '0, 2'b00, '0, '0);
    chk("ovf_err", 32'(bus.err_o), 1);
    chk("ovf_free", 32'(bus.free_cnt_o), 64);

    // Ten tags outstanding, then reset mid-RUN
    for (int i = 0; i < 5; i++)
      step(2'b11, 2'b00, '0, '0, 2'b11, tag_t'(2*i), tag_t'(2*i + 1));
    chk("out10_free", 32'(bus.free_cnt_o), 54);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.ready_o), 0);
    chk("midrst_err", 32'(bus.err_o), 0);
    chk("midrst_free", 32'(bus.free_cnt_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    chk("reinit_ready", 32'(bus.ready_o), 1);
    chk("reinit_free", 32'(bus.free_cnt_o), 64);
    chk("reinit_err", 32'(bus.err_o), 0);

    // Fresh list after re-init, then double retire of tag 3
    step(2'b11, 2'b00, '0, '0, 2'b11, 6'd0, 6'd1);
    step(2'b01, 2'b00, '0, '0, 2'b01, 6'd2, 6'd2);
    step(2'b01, 2'b00, '0, '0, 2'b01, 6'd3, 6'd3);
    chk("dfree_pre_free", 32'(bus.free_cnt_o), 60);
    step(2'b00, 2'b01, 6'd3, '0, 2'b00, '0, '0);
    chk("dfree_first_err", 32'(bus.err_o), 0);
    chk("dfree_first_free", 32'(bus.free_cnt_o), 61);
    step(2'b00, 2'b01, 6'd3, '0, 2'b00, '0, '0);
`ifdef TAG_POOL_DFREE_CHECK_EN
    chk("dfree_second_err", 32'(bus.err_o), 1);
    chk("dfree_second_free", 32'(bus.free_cnt_o), 61);
`else
    chk("dfree_second_err", 32'(bus.err_o), 0);
    chk("dfree_second_free", 32'(bus.free_cnt_o), 62);
`endif

    // Retire during INIT flags an error and is otherwise ignored
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(2'b00, 2'b01, 6'd1, '0, 2'b00, '0, '0);
    chk("init_ret_err", 32'(bus.err_o), 1);
    repeat (62) @(posedge clk);
    #1;
    chk("init_ret_ready0", 32'(bus.ready_o), 0);
    @(posedge clk); #1;
    chk("init_ret_ready1", 32'(bus.ready_o), 1);
    chk("init_ret_free", 32'(bus.free_cnt_o), 64);
    chk("init_ret_err_sticky", 32'(bus.err_o), 1);

    @(posedge clk); #1;
    chk("scoreboard_drain", 32'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
